// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// line-lock state encoding and the line-feed character that ends a locked line.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/uart_arb_fifo.sv
// 8-bit synchronous FIFO, one per requester. FIFO_DEPTH must be a power of two
// so the read/write pointers wrap naturally at their bit width.
module uart_arb_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push+pop together leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART from a CPU and a monitor queue.
// Define UART_ARB_LINE_LOCK_EN to keep a requester's line together until LF.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  input  logic       uart_io_full,
  output logic [7:0] uart_io_char,
  output logic       uart_io_we,
  output logic       arb_owner,
  output logic       arb_busy,
  output logic       timeout_evt
);

  localparam int            CW      = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    char_q, char_d;
  logic          we_q, we_d;
  logic          owner_q, owner_d;
  logic          evt_q, evt_d;

  logic       full0, full1, empty0, empty1;
  logic [7:0] rdata0, rdata1;
  logic       grant, grant_valid, pop, starve;
  logic [7:0] pop_char;

  uart_arb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (req0_valid),
    .wdata (req0_char),
    .pop   (pop & ~grant),
    .rdata (rdata0),
    .full  (full0),
    .empty (empty0)
  );

  uart_arb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (req1_valid),
    .wdata (req1_char),
    .pop   (pop & grant),
    .rdata (rdata1),
    .full  (full1),
    .empty (empty1)
  );

  assign req0_ready   = ~full0;
  assign req1_ready   = ~full1;
  assign uart_io_char = char_q;
  assign uart_io_we   = we_q;
  assign arb_owner    = owner_q;
  assign timeout_evt  = evt_q;
  assign arb_busy     = ~empty0 | ~empty1 | (state_q != IDLE);

  // Grant selection: a held lock pins the grant, otherwise alternate on contention.
  always_comb begin
    grant_valid = 1'b0;
    grant       = owner_q;
    case (state_q)
      LOCK0: begin
        grant_valid = ~empty0;
        grant       = 1'b0;
      end
      LOCK1: begin
        grant_valid = ~empty1;
        grant       = 1'b1;
      end
      IDLE: begin
        if (~empty0 && ~empty1) begin
          grant_valid = 1'b1;
          grant       = ~owner_q;
        end else if (~empty0) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else if (~empty1) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end else begin
          grant_valid = 1'b0;
          grant       = owner_q;
        end
      end
      default: begin
        grant_valid = 1'b0;
        grant       = owner_q;
      end
    endcase
    pop      = grant_valid & ~uart_io_full;
    pop_char = grant ? rdata1 : rdata0;
  end

  // Output datapath: strobe and character follow a pop by one edge.
  always_comb begin
    we_d    = pop;
    char_d  = pop ? pop_char : char_q;
    owner_d = pop ? grant : owner_q;
  end

  // Line-lock machine. Without the lock macro IDLE is never left, so the
  // counter and timeout pulse stay at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    starve  = ((state_q == LOCK0) && empty0 && ~empty1) ||
              ((state_q == LOCK1) && empty1 && ~empty0);
    if (uart_io_full) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (pop && (pop_char != LF)) begin
`ifdef UART_ARB_LINE_LOCK_EN
            state_d = grant ? LOCK1 : LOCK0;
`else
            state_d = IDLE;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        LOCK0, LOCK1: begin
          if (pop) begin
            cnt_d   = '0;
            state_d = (pop_char == LF) ? IDLE : state_q;
          end else if (starve) begin
            if (cnt_q == TO_LAST) begin
              state_d = IDLE;
              evt_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Arbiter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      we_q    <= 1'b0;
      owner_q <= 1'b1;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      we_q    <= we_d;
      owner_q <= owner_d;
      evt_q   <= evt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (FIFO_DEPTH=4, LOCK_TIMEOUT=16).
// Expectations follow UART_ARB_LINE_LOCK_EN when it is defined for the build.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_char;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_char;
  logic       req1_ready;
  logic       uart_io_full;
  logic [7:0] uart_io_char;
  logic       uart_io_we;
  logic       arb_owner;
  logic       arb_busy;
  logic       timeout_evt;

  int         n_cmp = 0;
  int         n_err = 0;
  int         base  = 0;
  int         n     = 0;
  logic [7:0] out_q [$];

  uart_tx_arbiter #(.FIFO_DEPTH(4), .LOCK_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_char    (req0_char),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_char    (req1_char),
    .req1_ready   (req1_ready),
    .uart_io_full (uart_io_full),
    .uart_io_char (uart_io_char),
    .uart_io_we   (uart_io_we),
    .arb_owner    (arb_owner),
    .arb_busy     (arb_busy),
    .timeout_evt  (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every character written to the UART, sampled mid-cycle.
  always @(negedge clk) begin
    if (uart_io_we) out_q.push_back(uart_io_char);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req0_char = 8'h00;
    req1_valid = 1'b0; req1_char = 8'h00;
    uart_io_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    base = out_q.size();
  endtask

  task automatic wait_out(input string tag, input int cnt, input int budget);
    int k;
    k = 0;
    while ((out_q.size() - base < cnt) && (k < budget)) begin
      tick();
      k++;
    end
    tick();
    chk(tag, 32'(out_q.size() - base), 32'(cnt));
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s[%0d]", tag, i), 32'(out_q[base + i]), 32'(e[i]));
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    req0_valid = 1'b0; req0_char = 8'h00;
    req1_valid = 1'b0; req1_char = 8'h00;
    uart_io_full = 1'b0;
    tick();
    tick();
    chk("rst_char",  32'(uart_io_char), 32'h00);
    chk("rst_we",    32'(uart_io_we),   32'h0);
    chk("rst_owner", 32'(arb_owner),    32'h1);
    chk("rst_busy",  32'(arb_busy),     32'h0);
    chk("rst_evt",   32'(timeout_evt),  32'h0);
    chk("rst_rdy0",  32'(req0_ready),   32'h1);
    chk("rst_rdy1",  32'(req1_ready),   32'h1);
    rst = 1'b0;
    tick();

    // Single character: strobe two edges after the push
    req0_valid = 1'b1; req0_char = 8'h41;
    tick();
    req0_valid = 1'b0;
    chk("single_we_t1",   32'(uart_io_we), 32'h0);
    chk("single_busy_t1", 32'(arb_busy),   32'h1);
    tick();
    chk("single_we_t2",    32'(uart_io_we),   32'h1);
    chk("single_char_t2",  32'(uart_io_char), 32'h41);
    chk("single_owner_t2", 32'(arb_owner),    32'h0);
    tick();
    chk("single_we_t3",   32'(uart_io_we),   32'h0);
    chk("single_hold_t3", 32'(uart_io_char), 32'h41);
`ifdef UART_ARB_LINE_LOCK_EN
    chk("single_busy_t3", 32'(arb_busy), 32'h1);
`else
    chk("single_busy_t3", 32'(arb_busy), 32'h0);
`endif

    // Contention, "AB" vs "xy" pushed in the same cycles
    do_reset();
    req0_valid = 1'b1; req0_char = 8'h41;
    req1_valid = 1'b1; req1_char = 8'h78;
    tick();
    req0_char = 8'h42;
    req1_char = 8'h79;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_out("ab_xy_cnt", 4, 60);
`ifdef UART_ARB_LINE_LOCK_EN
    chk_seq("ab_xy", 8'h41, 8'h42, 8'h78, 8'h79);
`else
    chk_seq("ab_xy", 8'h41, 8'h78, 8'h42, 8'h79);
`endif

    // req1 sends "hi\n" starting one cycle ahead of req0's "Z"
    do_reset();
    req1_valid = 1'b1; req1_char = 8'h68;
    tick();
    req1_char = 8'h69;
    req0_valid = 1'b1; req0_char = 8'h5A;
    tick();
    req1_char = 8'h0A;
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    wait_out("hi_z_cnt", 4, 40);
`ifdef UART_ARB_LINE_LOCK_EN
    chk_seq("hi_z", 8'h68, 8'h69, 8'h0A, 8'h5A);
`else
    chk_seq("hi_z", 8'h68, 8'h5A, 8'h69, 8'h0A);
`endif

    // Backpressure: four queued, UART full for ten cycles
    do_reset();
    uart_io_full = 1'b1;
    req0_valid = 1'b1;
    req0_char = 8'h11; tick();
    req0_char = 8'h22; tick();
    req0_char = 8'h33; tick();
    req0_char = 8'h44; tick();
    req0_valid = 1'b0;
    chk("bp_rdy0_full", 32'(req0_ready), 32'h0);
    for (int i = 0; i < 6; i++) tick();
    chk("bp_no_out",  32'(out_q.size() - base), 32'h0);
    chk("bp_we",      32'(uart_io_we),          32'h0);
    chk("bp_rdy0_hold", 32'(req0_ready),        32'h0);
    chk("bp_busy",    32'(arb_busy),            32'h1);
    uart_io_full = 1'b0;
    wait_out("bp_cnt", 4, 20);
    chk_seq("bp", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("bp_rdy0_after", 32'(req0_ready), 32'h1);

`ifdef UART_ARB_LINE_LOCK_EN
    // Lock timeout: req0 holds the line without LF while req1 waits
    do_reset();
    req0_valid = 1'b1; req0_char = 8'h61; tick();
    req0_char = 8'h62; tick();
    req0_valid = 1'b0; tick();
    req1_valid = 1'b1; req1_char = 8'h63; tick();
    req1_char = 8'h64; tick();
    req1_valid = 1'b0;
    n = 1;
    while (!timeout_evt && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_held_cnt", 32'(out_q.size() - base), 32'd2);
    tick();
    chk("to_pulse_end", 32'(timeout_evt),  32'h0);
    chk("to_first_we",  32'(uart_io_we),   32'h1);
    chk("to_first_ch",  32'(uart_io_char), 32'h63);
    wait_out("to_cnt", 4, 20);
    chk_seq("to", 8'h61, 8'h62, 8'h63, 8'h64);
`endif

    // Reset mid-stream with three characters queued
    do_reset();
    uart_io_full = 1'b1;
    req0_valid = 1'b1;
    req0_char = 8'h31; tick();
    req0_char = 8'h32; tick();
    req0_char = 8'h33; tick();
    req0_valid = 1'b0;
    uart_io_full = 1'b0;
    tick();
    chk("mid_we_before", 32'(uart_io_we), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_we",    32'(uart_io_we),   32'h0);
    chk("mid_char",  32'(uart_io_char), 32'h00);
    chk("mid_owner", 32'(arb_owner),    32'h1);
    chk("mid_busy",  32'(arb_busy),     32'h0);
    chk("mid_rdy0",  32'(req0_ready),   32'h1);
    base = out_q.size();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_no_out", 32'(out_q.size() - base), 32'h0);
    chk("mid_busy_after", 32'(arb_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the per-requester queue depth; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, the starvation limit in cycles for line lock.
REQ-003 Port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port req0_valid  input  1  CPU requester has a character.
REQ-006 Port req0_char  input  8  CPU character.
REQ-007 Port req0_ready  output  1  CPU queue not full.
REQ-008 Port req1_valid  input  1  monitor requester has a character.
REQ-009 Port req1_char  input  8  monitor character.
REQ-010 Port req1_ready  output  1  monitor queue not full.
REQ-011 Port uart_io_full  input  1  UART transmit buffer full.
REQ-012 Port uart_io_char  output  8  character to UART, registered.
REQ-013 Port uart_io_we  output  1  one-cycle write strobe to UART, registered.
REQ-014 Port arb_owner  output  1  last granted requester, 0 or 1.
REQ-015 Port arb_busy  output  1  high if any queue is non-empty or a lock is held.
REQ-016 Port timeout_evt  output  1  one-cycle pulse when a lock is force-released.

Function
REQ-017 Each requester SHALL own a FIFO_DEPTH-entry FIFO; reqN_ready = not full, with no look-ahead on a same-cycle pop; a push occurs when reqN_valid and reqN_ready are both high.
REQ-018 Pop rule: at most one character total per cycle, and only when the granted FIFO is non-empty and uart_io_full=0 in that cycle.
REQ-019 Pop effect: on the next edge, uart_io_char gets the popped character and uart_io_we=1; otherwise uart_io_we=0 and uart_io_char holds its value.
REQ-020 Latency: a push in cycle t into an empty FIFO on an idle arbiter SHALL give uart_io_we=1 in cycle t+2.
REQ-021 Arbitration SHALL be round-robin: if both FIFOs are non-empty, grant the requester other than arb_owner; otherwise grant the sole non-empty one.
REQ-022 arb_owner SHALL update on every pop to the popped requester.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a simultaneous push and pop on a non-full FIFO SHALL leave its count unchanged.
REQ-024 While uart_io_full=1, no pop SHALL occur; queued data and the arbitration state SHALL be held.

Reset
REQ-025 On rst high: FIFOs empty; uart_io_char=8'h00; uart_io_we=0; arb_owner=1 (so req0 wins first); arb_busy=0; timeout_evt=0; state IDLE; timeout counter 0.
REQ-026 rst asserted mid-operation SHALL discard all queued characters immediately, with no trailing uart_io_we.

Configuration
REQ-027 Macro UART_ARB_LINE_LOCK_EN SHALL add the line-lock state machine described in REQ-028 to REQ-031.
REQ-028 States are IDLE, LOCK0 and LOCK1. A pop from requester k in IDLE moves to LOCKk, unless the popped character is 8'h0A.
REQ-029 In LOCKk only requester k is granted; popping 8'h0A from k returns the machine to IDLE.
REQ-030 In LOCKk, the timeout counter increments each cycle that k's FIFO is empty and the other FIFO is non-empty, and clears otherwise. Reaching LOCK_TIMEOUT-1 forces IDLE, pulses timeout_evt, and clears the counter.
REQ-031 Without the macro, REQ-021 applies per character, the state stays IDLE, and timeout_evt is tied to 0.

Structure
REQ-032 Package uart_arb_pkg SHALL hold the state encoding (IDLE, LOCK0, LOCK1) and the constant LF = 8'h0A.
REQ-033 Sub-module uart_arb_fifo (8-bit synchronous FIFO, parameter FIFO_DEPTH) SHALL be instantiated once per requester.

Verification
REQ-034 Single character: push req0 0x41 at cycle 5 -> uart_io_we=1 with char 0x41 at cycle 7, and arb_owner=0.
REQ-035 Contention, lock off: req0 pushes "AB" and req1 pushes "xy" in the same cycles -> output order A, x, B, y.
REQ-036 Contention, lock on: req1 pushes "hi\n" and req0 pushes "Z", with req1 first -> output h, i, 0x0A, Z.
REQ-037 Backpressure: uart_io_full=1 for 10 cycles with 4 chars queued -> no uart_io_we, req0_ready=0; chars drain in order after full drops.
REQ-038 Timeout: lock held by req0 (sent "ab", no LF, FIFO empty) and req1 queued with LOCK_TIMEOUT=16 -> timeout_evt after 16 cycles, then req1 chars are output.
REQ-039 Reset mid-stream with 3 chars queued -> all outputs return to reset values at once, and no char is emitted afterwards.
